// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath constants: data/register-index widths, NZP bit positions
// and the condition-code type used by every stage that produces or consumes NZP.
package lc3_pkg;

  localparam int LC3_DATA_W     = 16;
  localparam int LC3_REG_ADDR_W = 3;

  localparam int CC_N = 2;
  localparam int CC_Z = 1;
  localparam int CC_P = 0;

  typedef logic [2:0] nzp_t;

  localparam nzp_t CC_RESET = 3'b010;

endpackage

// File: rtl/lc3_cc_gen.sv
// Combinational NZP encoder: classifies a two's-complement value as negative,
// zero or positive. Exactly one output bit is ever set.
module lc3_cc_gen
  import lc3_pkg::*;
#(
  parameter int DATA_W = LC3_DATA_W
) (
  input  logic [DATA_W-1:0] value,
  output logic [2:0]        nzp
);

  // NOTE: every output of an always_comb gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    nzp = '0;
    if (value == '0)
      nzp[CC_Z] = 1'b1;
    else if (value[DATA_W-1])
      nzp[CC_N] = 1'b1;
    else
      nzp[CC_P] = 1'b1;
  end

endmodule

// File: rtl/lc3_regfile_cc.sv
// LC-3 register file R0-R7 with NZP condition codes and BR condition evaluation.
// Optional build macro REGFILE_BYPASS_EN forwards the in-flight write to the read ports.
module lc3_regfile_cc
  import lc3_pkg::*;
#(
  parameter int         DATA_W   = LC3_DATA_W,
  parameter int         ADDR_W   = LC3_REG_ADDR_W,
  parameter logic [2:0] RESET_CC = CC_RESET
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] sr1_addr,
  input  logic [ADDR_W-1:0] sr2_addr,
  output logic [DATA_W-1:0] sr1_data,
  output logic [DATA_W-1:0] sr2_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] dr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ld_cc,
  output logic [2:0]        nzp,
  input  logic [2:0]        br_nzp,
  output logic              br_taken
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [0:NUM_REGS-1];
  nzp_t              nzp_q;
  nzp_t              cc_next;

  lc3_cc_gen #(.DATA_W(DATA_W)) u_cc_gen (
    .value (wr_data),
    .nzp   (cc_next)
  );

  // NOTE: this storage is cleared by reset, so it maps to flops rather than a
  // RAM macro; sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[dr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      nzp_q <= RESET_CC;
    else if (ld_cc)
      nzp_q <= cc_next;
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed during reset so a held write cannot leak out.
  always_comb begin
    sr1_data = regs[sr1_addr];
    sr2_data = regs[sr2_addr];
    if (wr_en && !rst && (sr1_addr == dr_addr)) sr1_data = wr_data;
    if (wr_en && !rst && (sr2_addr == dr_addr)) sr2_data = wr_data;
  end
`else
  assign sr1_data = regs[sr1_addr];
  assign sr2_data = regs[sr2_addr];
`endif

  // Branch decision uses committed codes only, never the value being written.
  assign nzp      = nzp_q;
  assign br_taken = |(br_nzp & nzp_q);

endmodule

// File: tb/tb_lc3_regfile_cc.sv
// Directed self-checking bench for lc3_regfile_cc; expectations follow the
// REGFILE_BYPASS_EN setting of the build for the same-cycle read case.
module tb_lc3_regfile_cc;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sr1_addr, sr2_addr, dr_addr;
  logic [15:0] sr1_data, sr2_data, wr_data;
  logic        wr_en, ld_cc;
  logic [2:0]  nzp, br_nzp;
  logic        br_taken;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model [0:7];

  lc3_regfile_cc dut (
    .clk      (clk),
    .rst      (rst),
    .sr1_addr (sr1_addr),
    .sr2_addr (sr2_addr),
    .sr1_data (sr1_data),
    .sr2_data (sr2_data),
    .wr_en    (wr_en),
    .dr_addr  (dr_addr),
    .wr_data  (wr_data),
    .ld_cc    (ld_cc),
    .nzp      (nzp),
    .br_nzp   (br_nzp),
    .br_taken (br_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      sr1_addr = 3'(i);
      sr2_addr = 3'(7 - i);
      #1;
      check($sformatf("%s sr1 R%0d", tag, i), sr1_data, model[i]);
      check($sformatf("%s sr2 R%0d", tag, 7 - i), sr2_data, model[7 - i]);
    end
  endtask

  task automatic write_reg(input logic [2:0] dr, input logic [15:0] d, input logic cc);
    dr_addr = dr;
    wr_data = d;
    wr_en   = 1'b1;
    ld_cc   = cc;
    tick();
    model[dr] = d;
    wr_en = 1'b0;
    ld_cc = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sr1_addr = '0; sr2_addr = '0; dr_addr = '0;
    wr_data = '0; wr_en = 1'b0; ld_cc = 1'b0; br_nzp = 3'b010;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;

    // 1: reset state
    #12;
    check("rst nzp", 16'(nzp), 16'h0002);
    check("rst sr1", sr1_data, 16'h0000);
    tick();
    rst = 1'b0;
    #1;
    check_all_regs("after reset");
    check("rst br_taken z", 16'(br_taken), 16'h0001);
    br_nzp = 3'b000; #1;
    check("br mask 000", 16'(br_taken), 16'h0000);
    br_nzp = 3'b111; #1;
    check("br mask 111", 16'(br_taken), 16'h0001);

    // 2: positive write with CC update
    write_reg(3'd3, 16'h1234, 1'b1);
    sr1_addr = 3'd3; #1;
    check("R3 read", sr1_data, 16'h1234);
    check("nzp positive", 16'(nzp), 16'h0001);

    // 3: negative write, branch masks
    write_reg(3'd5, 16'h8000, 1'b1);
    sr2_addr = 3'd5; #1;
    check("R5 read", sr2_data, 16'h8000);
    check("nzp negative", 16'(nzp), 16'h0004);
    br_nzp = 3'b011; #1;
    check("br zp on N", 16'(br_taken), 16'h0000);
    br_nzp = 3'b100; #1;
    check("br n on N", 16'(br_taken), 16'h0001);

    // 4: CC-only update from zero, registers untouched
    dr_addr = 3'd3; wr_data = 16'h0000; wr_en = 1'b0; ld_cc = 1'b1;
    tick();
    ld_cc = 1'b0;
    check("nzp zero cc-only", 16'(nzp), 16'h0002);
    check_all_regs("cc-only");

    // Register write without CC update; R0 is an ordinary register
    write_reg(3'd7, 16'h7FFF, 1'b0);
    check("nzp held no ld_cc", 16'(nzp), 16'h0002);
    write_reg(3'd0, 16'h0001, 1'b0);
    sr1_addr = 3'd0; sr2_addr = 3'd7; #1;
    check("R0 writable", sr1_data, 16'h0001);
    check("R7 read", sr2_data, 16'h7FFF);

    // 5: same-cycle read of the register being written
    sr1_addr = 3'd2; sr2_addr = 3'd2;
    dr_addr = 3'd2; wr_data = 16'hBEEF; wr_en = 1'b1; ld_cc = 1'b1; br_nzp = 3'b100;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same-cycle sr1", sr1_data, 16'hBEEF);
    check("same-cycle sr2", sr2_data, 16'hBEEF);
`else
    check("same-cycle sr1", sr1_data, 16'h0000);
    check("same-cycle sr2", sr2_data, 16'h0000);
`endif
    check("nzp not bypassed", 16'(nzp), 16'h0002);
    check("br not bypassed", 16'(br_taken), 16'h0000);
    tick();
    model[2] = 16'hBEEF;
    wr_en = 1'b0; ld_cc = 1'b0;
    check("next-cycle sr1", sr1_data, 16'hBEEF);
    check("next-cycle sr2", sr2_data, 16'hBEEF);
    check("nzp after BEEF", 16'(nzp), 16'h0004);
    check("br after BEEF", 16'(br_taken), 16'h0001);

    // 6: asynchronous reset mid-cycle during a write
    sr1_addr = 3'd3; sr2_addr = 3'd4;
    dr_addr = 3'd4; wr_data = 16'hAAAA; wr_en = 1'b1; ld_cc = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async rst sr1", sr1_data, 16'h0000);
    check("async rst nzp", 16'(nzp), 16'h0002);
    tick();
    rst = 1'b0; wr_en = 1'b0; ld_cc = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    #1;
    check("write discarded nzp", 16'(nzp), 16'h0002);
    check_all_regs("after async reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
